// File: rtl/zero_detector_scheduler.sv
// rtl/zero_detector_scheduler.sv - round-robin time-sharing of one Mealy zero-detector; option macro ZDS_PRIORITY_EN
module zero_detector_scheduler #(
   parameter int N_REQ    = 4,
   parameter int SLOT_LEN = 16,
   localparam int ID_W    = $clog2(N_REQ),
   localparam int CNT_W   = $clog2(SLOT_LEN + 1),
   localparam int LEN_W   = $clog2(SLOT_LEN + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N_REQ-1:0]  req,
   input  logic [N_REQ-1:0]  x_req,
   output logic [N_REQ-1:0]  gnt,
   output logic              det_x,
   output logic              det_reset_n,
   input  logic              det_y,
   output logic              rpt_valid,
   output logic [ID_W-1:0]   rpt_id,
   output logic [CNT_W-1:0]  rpt_count,
   output logic              rpt_abort
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FLUSH  = 2'd1;
   localparam logic [1:0] S_RUN    = 2'd2;
   localparam logic [1:0] S_REPORT = 2'd3;

`ifdef ZDS_PRIORITY_EN
   localparam bit PRIO_EN = 1'b1;
`else
   localparam bit PRIO_EN = 1'b0;
`endif

   logic [1:0]       state;
   logic [ID_W-1:0]  owner;
   logic [ID_W-1:0]  rr;
   logic [CNT_W-1:0] count;
   logic [LEN_W-1:0] len;
   logic             slot_abort;

   logic [ID_W-1:0]  pick;
   logic             pick_ok;
   logic [ID_W-1:0]  idx_w;
   int               idx;
   logic [ID_W-1:0]  next_rr;

   // Arbitration: requester 0 first when prioritised, else first set request at or after rr
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      idx     = 0;
      idx_w   = '0;
      if (PRIO_EN && req[0]) begin
         pick_ok = 1'b1;
      end
      for (int k = 0; k < N_REQ; k++) begin
         idx   = (int'(rr) + k) % N_REQ;
         idx_w = ID_W'(idx);
         if (!pick_ok && req[idx_w] && !(PRIO_EN && idx == 0)) begin
            pick    = idx_w;
            pick_ok = 1'b1;
         end
      end
   end

   assign next_rr = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

   // Slot sequencing: grant, flush the detector, run, then report once
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         owner      <= '0;
         rr         <= '0;
         count      <= '0;
         len        <= '0;
         slot_abort <= 1'b0;
         gnt        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_ok) begin
                  owner      <= pick;
                  gnt        <= N_REQ'(1) << pick;
                  count      <= '0;
                  len        <= '0;
                  slot_abort <= 1'b0;
                  state      <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               state <= S_RUN;
            end
            S_RUN: begin
               // A dropped request ends the slot and its bit on this edge is discarded
               if (!req[owner]) begin
                  slot_abort <= 1'b1;
                  state      <= S_REPORT;
               end else begin
                  len <= len + 1'b1;
                  if (det_y && (count != '1)) begin
                     count <= count + 1'b1;
                  end
                  if (len == LEN_W'(SLOT_LEN - 1)) begin
                     state <= S_REPORT;
                  end
               end
            end
            S_REPORT: begin
               gnt <= '0;
               // A priority slot of requester 0 leaves the rotation untouched
               if (!(PRIO_EN && owner == '0)) begin
                  rr <= next_rr;
               end
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign det_reset_n = (state == S_RUN);
   assign det_x       = (state == S_RUN) && x_req[owner];
   assign rpt_valid   = (state == S_REPORT);
   assign rpt_id      = owner;
   assign rpt_count   = count;
   assign rpt_abort   = slot_abort;

endmodule

// File: tb/tb_zero_detector_scheduler.sv
// tb/tb_zero_detector_scheduler.sv - scoreboard bench for zero_detector_scheduler; honours ZDS_PRIORITY_EN
module tb_zero_detector_scheduler;

   localparam int N   = 4;
   localparam int SL  = 16;
   localparam int IDW = 2;
   localparam int CW  = 5;

   logic           clock = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [N-1:0]   x_req;
   logic [N-1:0]   gnt;
   logic           det_x;
   logic           det_reset_n;
   logic           det_y;
   logic           rpt_valid;
   logic [IDW-1:0] rpt_id;
   logic [CW-1:0]  rpt_count;
   logic           rpt_abort;

   typedef struct {
      int id;
      int count;
      int abort;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;
   int   rr_m   = 0;
   logic noise  = 1'b0;
   logic det_prev;

   zero_detector_scheduler #(.N_REQ(N), .SLOT_LEN(SL)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .x_req       (x_req),
      .gnt         (gnt),
      .det_x       (det_x),
      .det_reset_n (det_reset_n),
      .det_y       (det_y),
      .rpt_valid   (rpt_valid),
      .rpt_id      (rpt_id),
      .rpt_count   (rpt_count),
      .rpt_abort   (rpt_abort)
   );

   always #5 clock = ~clock;

   // Cycle counter used to time-stamp reports
   always @(posedge clock) cyc <= cyc + 1;

   // External detector: flags a 1->0 transition; junk on det_y while held in reset
   always @(posedge clock) det_prev <= det_reset_n ? det_x : 1'b0;
   assign det_y = det_reset_n ? (det_prev & ~det_x) : noise;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic step();
      @(negedge clock);
      #1;
      noise = 1'($urandom);
   endtask

   // Reference arbitration straight from the fairness rules
   function automatic int pick(input logic [N-1:0] m, input int rr);
`ifdef ZDS_PRIORITY_EN
      if (m[0]) return 0;
`endif
      for (int k = 0; k < N; k++) begin
         int id = (rr + k) % N;
`ifdef ZDS_PRIORITY_EN
         if (id == 0) continue;
`endif
         if (m[id]) return id;
      end
      return -1;
   endfunction

   // ab: 0 full slot, -1 drop during FLUSH, 1..SL drop at that RUN cycle
   task automatic run_slot(input logic [N-1:0] m, input int ab, input int gap,
                           input bit use_bits, input logic [SL-1:0] bits);
      int w;
      int t0;
      int len;
      int cnt;
      logic prev;
      logic [N-1:0] xs[SL];
      logic [N-1:0] rs[SL];
      logic [N-1:0] rf;
      w   = pick(m, rr_m);
      len = (ab == 0) ? SL : ((ab < 0) ? 1 : ab);
      cnt = 0;
      prev = 1'b0;
      for (int i = 0; i < len; i++) begin
         xs[i] = N'($urandom);
         if (use_bits) xs[i][w] = bits[i];
         rs[i] = N'($urandom);
         rs[i][w] = !(ab < 0 || i + 1 == ab);
         if (!(ab != 0 && i == len - 1)) begin
            if (prev && !xs[i][w]) cnt++;
            prev = xs[i][w];
         end
      end
      rf = N'($urandom) | (N'(1) << w);
      if (ab < 0) rf[w] = 1'b0;
      t0 = cyc;
      sb.push_back('{w, cnt, (ab != 0) ? 1 : 0, t0 + 2 + len});
`ifdef ZDS_PRIORITY_EN
      if (w != 0) rr_m = (w + 1) % N;
`else
      rr_m = (w + 1) % N;
`endif
      req = m;
      x_req = N'($urandom);
      step();
      req = rf;
      x_req = N'($urandom);
      step();
      for (int i = 0; i < len; i++) begin
         req = rs[i];
         x_req = xs[i];
         step();
      end
      req = N'($urandom);
      x_req = N'($urandom);
      step();
      repeat (gap) begin
         req = '0;
         step();
      end
   endtask

   // Monitor: every report is matched against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (rpt_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_report: got id %0d count %0d, required no report", rpt_id, rpt_count);
            end else begin
               e = sb.pop_front();
               chk("rpt_id", 32'(rpt_id), e.id);
               chk("rpt_count", 32'(rpt_count), e.count);
               chk("rpt_abort", 32'(rpt_abort), e.abort);
               chk("rpt_cycle", cyc, e.cyc);
               chk("rpt_gnt", 32'(gnt), 32'(1) << e.id);
               chk("rpt_det_reset_n", 32'(det_reset_n), 0);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      req   = 4'b1111;
      x_req = '0;
      repeat (2) begin
         @(negedge clock);
         chk("reset_gnt", 32'(gnt), 0);
         chk("reset_det_reset_n", 32'(det_reset_n), 0);
         chk("reset_rpt_valid", 32'(rpt_valid), 0);
      end
      #1;
      reset = 1'b0;
      req   = '0;
      step();

      run_slot(4'b0010, 0, 1, 1'b1, 16'hFFD3);
      for (int s = 0; s < 5; s++) run_slot(4'b1111, 0, 0, 1'b0, '0);
      run_slot(4'b0100, 5, 1, 1'b0, '0);
      run_slot(4'b1000, -1, 0, 1'b0, '0);
      run_slot(4'b0001, SL, 0, 1'b0, '0);

      // Reset in RUN cycle 8 kills the slot without a report
      req = 4'b0100;
      x_req = N'($urandom);
      step();
      repeat (8) step();
      reset = 1'b1;
      #1;
      chk("midreset_gnt", 32'(gnt), 0);
      chk("midreset_det_reset_n", 32'(det_reset_n), 0);
      step();
      chk("midreset_rpt_valid", 32'(rpt_valid), 0);
      reset = 1'b0;
      rr_m = 0;
      req = '0;
      step();
      run_slot(4'b0100, 0, 0, 1'b0, '0);
      run_slot(4'b1111, 0, 0, 1'b0, '0);

      run_slot(4'b1110, 0, 0, 1'b0, '0);
      run_slot(4'b1111, 0, 0, 1'b0, '0);
      run_slot(4'b1111, 0, 1, 1'b0, '0);

      for (int s = 0; s < 30; s++) begin
         logic [N-1:0] m;
         int sel;
         int ab;
         m = N'($urandom_range(1, (1 << N) - 1));
         sel = $urandom_range(0, 5);
         ab = (sel <= 2) ? 0 : ((sel == 3) ? -1 : $urandom_range(1, SL));
         run_slot(m, ab, $urandom_range(0, 2), 1'b0, '0);
      end

      req = '0;
      repeat (4) step();
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
